// File: rtl/cpu_in_port.sv
// cpu_in_port: input-direction counterpart of the CPU output register.
// An external producer pushes nibbles into a small FIFO. The head entry is
// presented on the shared CPU bus while oe is high.
//
// Parameters:
//   DEPTH     FIFO entry count (power of two, 2..16)
//
// Ports:
//   clk       system clock, rising-edge active
//   rst       synchronous reset, active-low
//   bus       shared CPU bus; driven {~empty,3'b000,head} while oe=1, else Z
//   oe        combinational bus output enable
//   pop       dequeue the head entry at the next rising edge (ignored when empty)
//   in_data   nibble offered by the producer
//   in_valid  producer qualifier for in_data
//   in_ready  block can accept a nibble this cycle (= !full)
//   empty     FIFO holds zero entries
//   full      FIFO holds DEPTH entries
//   count     current occupancy, 0..DEPTH
//   ovf       sticky overflow flag
//
// Build option:
//   CPU_IN_PORT_OVF_EN  when defined, ovf sets at an edge where in_valid=1
//                       and full=1. It clears on a successful pop or on
//                       reset; set wins over clear. When undefined, ovf is
//                       tied to 0.
module cpu_in_port #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  inout  wire  [7:0]                 bus,
  input  logic                       oe,
  input  logic                       pop,
  input  logic [3:0]                 in_data,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       empty,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     count,
  output logic                       ovf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = $clog2(DEPTH) + 1;
  localparam logic [PW-1:0] PTR_ONE = PW'(1);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam logic [CW-1:0] CNT_MAX = CW'(DEPTH);

  logic [3:0]    mem [DEPTH];
  logic [PW-1:0] head;
  logic [PW-1:0] tail;
  logic [CW-1:0] cnt;
  logic          do_push;
  logic          do_pop;
  logic [3:0]    head_nibble;

  assign empty    = (cnt == '0);
  assign full     = (cnt == CNT_MAX);
  assign in_ready = !full;
  assign count    = cnt;

  // A push is gated only by full and a pop only by empty. Therefore a push
  // into an empty FIFO with pop=1 is accepted while the pop is ignored. A
  // pop on a full FIFO proceeds even though the same-cycle push is refused.
  assign do_push = in_valid && !full;
  assign do_pop  = pop && !empty;

  always_ff @(posedge clk) begin
    if (!rst) begin
      head <= '0;
      tail <= '0;
      cnt  <= '0;
    end else begin
      if (do_push) tail <= tail + PTR_ONE;
      if (do_pop)  head <= head + PTR_ONE;
      unique case ({do_push, do_pop})
        2'b10:   cnt <= cnt + CNT_ONE;
        2'b01:   cnt <= cnt - CNT_ONE;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage is not cleared on reset. The write is still suppressed while
  // rst is low, so an in-flight push is discarded.
  always_ff @(posedge clk) begin
    if (rst && do_push) mem[tail] <= in_data;
  end

  assign head_nibble = empty ? 4'h0 : mem[head];
  assign bus = oe ? {~empty, 3'b000, head_nibble} : 8'bzzzz_zzzz;

`ifdef CPU_IN_PORT_OVF_EN
  logic ovf_q;

  always_ff @(posedge clk) begin
    if (!rst)
      ovf_q <= 1'b0;
    else if (in_valid && full)
      ovf_q <= 1'b1;
    else if (do_pop)
      ovf_q <= 1'b0;
  end

  assign ovf = ovf_q;
`else
  assign ovf = 1'b0;
`endif

endmodule
